// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : vga_timing_pkg                                                 |
// | Purpose : Shared constants, types and helper functions for the VGA       |
// |           pixel-timing generator (1280x1024@60 Hz, 108 MHz pixel clock). |
// | Ports   : none (package)                                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package vga_timing_pkg;

   // Coordinate counter width and the largest total it can represent.
   localparam int C_COORD_W     = 12;
   localparam int C_COORD_LIMIT = 1 << C_COORD_W;

   // 1280x1024@60 Hz default mode.
   localparam int C_DEF_H_VISIBLE = 1280;
   localparam int C_DEF_H_FP      = 48;
   localparam int C_DEF_H_SYNC    = 112;
   localparam int C_DEF_H_BP      = 248;
   localparam int C_DEF_V_VISIBLE = 1024;
   localparam int C_DEF_V_FP      = 1;
   localparam int C_DEF_V_SYNC    = 3;
   localparam int C_DEF_V_BP      = 38;

   typedef logic [C_COORD_W-1:0] coord_t;

   // Bundle carried through the output delay line.
   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } sync_bus_t;

   function automatic int calc_total(input int visible, input int fp,
                                     input int sync, input int bp);
      return visible + fp + sync + bp;
   endfunction

   // First coordinate of the sync pulse.
   function automatic int calc_sync_start(input int visible, input int fp);
      return visible + fp;
   endfunction

   // First coordinate after the sync pulse (exclusive end).
   function automatic int calc_sync_end(input int visible, input int fp,
                                        input int sync);
      return visible + fp + sync;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: vga_timing_gen_if                                             |
// | Purpose  : Timing bus between the pixel-timing generator (master) and    |
// |            the render pipeline / pin drivers (slave).                    |
// | Signals  : PIX_EN          - advance enable (slave -> master)            |
// |            VGA_horzCoord   - current column                              |
// |            VGA_vertCoord   - current row                                 |
// |            VGA_active      - coordinate is in the visible area           |
// |            VGA_HS, VGA_VS  - undelayed syncs for the current coordinate  |
// |            line_start      - one-clock strobe on entry to column 0       |
// |            frame_start     - one-clock strobe on entry to (0,0)          |
// |            VGA_*_OUT       - syncs/active delayed to match pixel colour  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic   PIX_EN;
   coord_t VGA_horzCoord;
   coord_t VGA_vertCoord;
   logic   VGA_active;
   logic   VGA_HS;
   logic   VGA_VS;
   logic   line_start;
   logic   frame_start;
   logic   VGA_HS_OUT;
   logic   VGA_VS_OUT;
   logic   VGA_active_OUT;

   modport master (
      input  PIX_EN,
      output VGA_horzCoord, VGA_vertCoord, VGA_active, VGA_HS, VGA_VS,
             line_start, frame_start, VGA_HS_OUT, VGA_VS_OUT, VGA_active_OUT
   );

   modport slave (
      output PIX_EN,
      input  VGA_horzCoord, VGA_vertCoord, VGA_active, VGA_HS, VGA_VS,
             line_start, frame_start, VGA_HS_OUT, VGA_VS_OUT, VGA_active_OUT
   );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sync_delay_line                                                |
// | Purpose : DEPTH-stage shift register with enable and synchronous reset   |
// |           of every stage to INIT. DEPTH = 0 is a pure wire.              |
// | Ports   : clk  - clock                                                   |
// |           rst  - synchronous active-high reset                           |
// |           i_en - shift enable                                            |
// |           i_d  - data in                                                 |
// |           o_q  - data out, DEPTH enabled cycles later                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sync_delay_line #(
   parameter int               WIDTH = 3,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_en,
   input  wire logic [WIDTH-1:0] i_d,
   output logic      [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         // Clock, reset and enable have no job when there is no storage.
         logic w_unused;
         assign w_unused = &{1'b0, clk, rst, i_en};
         assign o_q      = i_d;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_stage [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_stage[i] <= INIT;
               end
            end else if (i_en) begin
               r_stage[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_q = r_stage[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vga_timing_gen                                                 |
// | Purpose : Free-running horizontal/vertical pixel counters with decoded   |
// |           sync, blanking and line/frame strobes, plus a delay line that  |
// |           keeps the pin-level syncs aligned with the render pipeline.    |
// | Ports   : CLK_VGA - pixel clock                                          |
// |           RESET   - synchronous active-high reset                        |
// |           vga     - timing bus (master side), see vga_timing_gen_if      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = C_DEF_H_VISIBLE,
   parameter int H_FP       = C_DEF_H_FP,
   parameter int H_SYNC     = C_DEF_H_SYNC,
   parameter int H_BP       = C_DEF_H_BP,
   parameter int V_VISIBLE  = C_DEF_V_VISIBLE,
   parameter int V_FP       = C_DEF_V_FP,
   parameter int V_SYNC     = C_DEF_V_SYNC,
   parameter int V_BP       = C_DEF_V_BP,
   parameter bit SYNC_POL   = 1'b1,
   parameter int PIPE_DEPTH = 2
) (
   input wire logic         CLK_VGA,
   input wire logic         RESET,
   vga_timing_gen_if.master vga
);

   localparam int C_H_TOTAL  = calc_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
   localparam int C_V_TOTAL  = calc_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
   localparam int C_HS_START = calc_sync_start(H_VISIBLE, H_FP);
   localparam int C_HS_END   = calc_sync_end(H_VISIBLE, H_FP, H_SYNC);
   localparam int C_VS_START = calc_sync_start(V_VISIBLE, V_FP);
   localparam int C_VS_END   = calc_sync_end(V_VISIBLE, V_FP, V_SYNC);

   // Idle level of everything in the delay line: syncs deasserted, blanked.
   localparam sync_bus_t C_SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0};

   // Elaboration-time sanity checks on the configuration.
   if (C_H_TOTAL > C_COORD_LIMIT) begin : g_chk_h_total
      $error("vga_timing_gen: H_TOTAL exceeds the coordinate counter range");
   end
   if (C_V_TOTAL > C_COORD_LIMIT) begin : g_chk_v_total
      $error("vga_timing_gen: V_TOTAL exceeds the coordinate counter range");
   end
   if (PIPE_DEPTH < 0 || PIPE_DEPTH > 8) begin : g_chk_depth
      $error("vga_timing_gen: PIPE_DEPTH must lie in 0..8");
   end

   coord_t    r_h;
   coord_t    r_v;
   logic      r_active;
   logic      r_hs;
   logic      r_vs;
   logic      r_line_start;
   logic      r_frame_start;

   logic      w_h_wrap;
   logic      w_v_wrap;
   coord_t    w_h_nxt;
   coord_t    w_v_nxt;
   logic      w_active_nxt;
   logic      w_hs_nxt;
   logic      w_vs_nxt;
   sync_bus_t w_sync_d;
   sync_bus_t w_sync_q;

   // Next coordinate; the decode below works on it so that the registered
   // levels always describe the coordinate registered alongside them.
   assign w_h_wrap = (r_h == coord_t'(C_H_TOTAL - 1));
   assign w_v_wrap = (r_v == coord_t'(C_V_TOTAL - 1));
   assign w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
   assign w_v_nxt  = !w_h_wrap ? r_v : (w_v_wrap ? '0 : r_v + 1'b1);

   assign w_active_nxt = (int'(w_h_nxt) < H_VISIBLE) && (int'(w_v_nxt) < V_VISIBLE);
   assign w_hs_nxt     = ((int'(w_h_nxt) >= C_HS_START) && (int'(w_h_nxt) < C_HS_END))
                         ? SYNC_POL : ~SYNC_POL;
   assign w_vs_nxt     = ((int'(w_v_nxt) >= C_VS_START) && (int'(w_v_nxt) < C_VS_END))
                         ? SYNC_POL : ~SYNC_POL;

   // Reset parks the counters on the last back-porch pixel so the first
   // advance lands on (0,0) with both strobes.
   always_ff @(posedge CLK_VGA) begin
      if (RESET) begin
         r_h           <= coord_t'(C_H_TOTAL - 1);
         r_v           <= coord_t'(C_V_TOTAL - 1);
         r_active      <= 1'b0;
         r_hs          <= ~SYNC_POL;
         r_vs          <= ~SYNC_POL;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         // Strobes last one clock even when the next edge does not advance.
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         if (vga.PIX_EN) begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_active      <= w_active_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
         end
      end
   end

   assign w_sync_d = '{hs: r_hs, vs: r_vs, active: r_active};

   sync_delay_line #(
      .WIDTH ($bits(sync_bus_t)),
      .DEPTH (PIPE_DEPTH),
      .INIT  (C_SYNC_IDLE)
   ) u_sync_delay (
      .clk  (CLK_VGA),
      .rst  (RESET),
      .i_en (vga.PIX_EN),
      .i_d  (w_sync_d),
      .o_q  (w_sync_q)
   );

   assign vga.VGA_horzCoord  = r_h;
   assign vga.VGA_vertCoord  = r_v;
   assign vga.VGA_active     = r_active;
   assign vga.VGA_HS         = r_hs;
   assign vga.VGA_VS         = r_vs;
   assign vga.line_start     = r_line_start;
   assign vga.frame_start    = r_frame_start;
   assign vga.VGA_HS_OUT     = w_sync_q.hs;
   assign vga.VGA_VS_OUT     = w_sync_q.vs;
   assign vga.VGA_active_OUT = w_sync_q.active;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_vga_timing_gen                                              |
// | Purpose : Self-checking bench for vga_timing_gen. Three instances: the   |
// |           default 1280x1024 mode (depth 2), a small mode (depth 3) and a |
// |           small negative-sync mode (depth 0). Outputs are compared to a  |
// |           reference that derives every value from the advance count.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] pe  = 3'b111;
   bit         chk_en = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   // Geometry of the three instances.
   int g_hv [3] = '{1280, 16, 10};
   int g_hf [3] = '{48, 2, 1};
   int g_hs [3] = '{112, 3, 2};
   int g_hb [3] = '{248, 4, 3};
   int g_vv [3] = '{1024, 8, 6};
   int g_vf [3] = '{1, 1, 1};
   int g_vs [3] = '{3, 2, 1};
   int g_vb [3] = '{38, 3, 2};
   bit g_pol[3] = '{1'b1, 1'b1, 1'b0};
   int g_d  [3] = '{2, 3, 0};

   vga_timing_gen_if if0();
   vga_timing_gen_if if1();
   vga_timing_gen_if if2();

   assign if0.PIX_EN = pe[0];
   assign if1.PIX_EN = pe[1];
   assign if2.PIX_EN = pe[2];

   vga_timing_gen #(.PIPE_DEPTH(2)) dut0 (.CLK_VGA(clk), .RESET(rst), .vga(if0));

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_VISIBLE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b1), .PIPE_DEPTH(3)
   ) dut1 (.CLK_VGA(clk), .RESET(rst), .vga(if1));

   vga_timing_gen #(
      .H_VISIBLE(10), .H_FP(1), .H_SYNC(2), .H_BP(3),
      .V_VISIBLE(6),  .V_FP(1), .V_SYNC(1), .V_BP(2),
      .SYNC_POL(1'b0), .PIPE_DEPTH(0)
   ) dut2 (.CLK_VGA(clk), .RESET(rst), .vga(if2));

   // {h, v, active, HS, VS, line_start, frame_start, HS_OUT, VS_OUT, active_OUT}
   wire [31:0] obs0 = {if0.VGA_horzCoord, if0.VGA_vertCoord, if0.VGA_active, if0.VGA_HS,
                       if0.VGA_VS, if0.line_start, if0.frame_start, if0.VGA_HS_OUT,
                       if0.VGA_VS_OUT, if0.VGA_active_OUT};
   wire [31:0] obs1 = {if1.VGA_horzCoord, if1.VGA_vertCoord, if1.VGA_active, if1.VGA_HS,
                       if1.VGA_VS, if1.line_start, if1.frame_start, if1.VGA_HS_OUT,
                       if1.VGA_VS_OUT, if1.VGA_active_OUT};
   wire [31:0] obs2 = {if2.VGA_horzCoord, if2.VGA_vertCoord, if2.VGA_active, if2.VGA_HS,
                       if2.VGA_VS, if2.line_start, if2.frame_start, if2.VGA_HS_OUT,
                       if2.VGA_VS_OUT, if2.VGA_active_OUT};

   // Reference state: number of advances since reset, and whether the most
   // recent edge advanced.
   longint n_adv [3] = '{0, 0, 0};
   bit     adv   [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            n_adv[i] <= 0;
            adv[i]   <= 1'b0;
         end else if (pe[i]) begin
            n_adv[i] <= n_adv[i] + 1;
            adv[i]   <= 1'b1;
         end else begin
            adv[i]   <= 1'b0;
         end
      end
   end

   // Position and decoded levels after n advances: {h, v, active, HS, VS}.
   function automatic logic [26:0] decode(input int id, input longint n);
      int     ht, vt, h, v;
      longint k;
      logic   a, hs, vs;
      ht = g_hv[id] + g_hf[id] + g_hs[id] + g_hb[id];
      vt = g_vv[id] + g_vf[id] + g_vs[id] + g_vb[id];
      if (n <= 0) begin
         h = ht - 1;
         v = vt - 1;
      end else begin
         k = (n - 1) % longint'(ht * vt);
         h = int'(k % ht);
         v = int'(k / ht);
      end
      a  = (h < g_hv[id]) && (v < g_vv[id]);
      hs = (h >= g_hv[id] + g_hf[id] && h < g_hv[id] + g_hf[id] + g_hs[id])
           ? g_pol[id] : ~g_pol[id];
      vs = (v >= g_vv[id] + g_vf[id] && v < g_vv[id] + g_vf[id] + g_vs[id])
           ? g_pol[id] : ~g_pol[id];
      return {h[11:0], v[11:0], a, hs, vs};
   endfunction

   function automatic logic [31:0] model_vec(input int id);
      logic [26:0] cur, dly;
      logic        ls, fs;
      cur = decode(id, n_adv[id]);
      dly = decode(id, n_adv[id] - g_d[id]);
      ls  = adv[id] && (cur[26:15] == 12'd0);
      fs  = ls && (cur[14:3] == 12'd0);
      return {cur, ls, fs, dly[1], dly[0], dly[2]};
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp($sformatf("model0 n=%0d", n_adv[0]), obs0, model_vec(0));
         cmp($sformatf("model1 n=%0d", n_adv[1]), obs1, model_vec(1));
         cmp($sformatf("model2 n=%0d", n_adv[2]), obs2, model_vec(2));
      end
   end

   // Directed vectors for the small instance (dut1): HT=25, HS=[18,21),
   // VT=14, VS=[9,11). ncyc edges are applied, then outputs are compared.
   typedef struct {
      bit       rst;
      bit       pe;
      int       ncyc;
      int       h;
      int       v;
      bit [4:0] f;   // {active, HS, VS, line_start, frame_start}
   } vec_t;

   function automatic vec_t mk(input bit r, input bit p, input int nc,
                               input int h, input int v, input bit [4:0] f);
      vec_t t;
      t.rst = r; t.pe = p; t.ncyc = nc; t.h = h; t.v = v; t.f = f;
      return t;
   endfunction

   vec_t tbl [16];

   initial begin
      int act_fall_h, hs_rise_h, hs_fall_h, hs_rise_i, hso_rise_i, wrap_v, ls_cnt;
      int fs_cnt, fs_first, fs_second;
      logic p_act, p_hs, p_hso;
      logic [31:0] snap;
      logic [11:0] eh, ev;

      tbl[0]  = mk(1'b1, 1'b1,   1, 24, 13, 5'b00000);
      tbl[1]  = mk(1'b0, 1'b1,   1,  0,  0, 5'b10011);
      tbl[2]  = mk(1'b0, 1'b0,   1,  0,  0, 5'b10000);
      tbl[3]  = mk(1'b0, 1'b1,  15, 15,  0, 5'b10000);
      tbl[4]  = mk(1'b0, 1'b1,   1, 16,  0, 5'b00000);
      tbl[5]  = mk(1'b0, 1'b1,   2, 18,  0, 5'b01000);
      tbl[6]  = mk(1'b0, 1'b1,   2, 20,  0, 5'b01000);
      tbl[7]  = mk(1'b0, 1'b1,   1, 21,  0, 5'b00000);
      tbl[8]  = mk(1'b0, 1'b1,   3, 24,  0, 5'b00000);
      tbl[9]  = mk(1'b0, 1'b1,   1,  0,  1, 5'b10010);
      tbl[10] = mk(1'b0, 1'b0,   5,  0,  1, 5'b10000);
      tbl[11] = mk(1'b0, 1'b1, 200,  0,  9, 5'b00110);
      tbl[12] = mk(1'b0, 1'b1,  50,  0, 11, 5'b00010);
      tbl[13] = mk(1'b0, 1'b1,  74, 24, 13, 5'b00000);
      tbl[14] = mk(1'b0, 1'b1,   1,  0,  0, 5'b10011);
      tbl[15] = mk(1'b1, 1'b0,   1, 24, 13, 5'b00000);

      // Reset state of the default instance.
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      cmp("reset_state", obs0, {12'd1687, 12'd1065, 8'b0000_0000});

      // First advance after release.
      rst = 1'b0;
      @(negedge clk);
      cmp("first_advance", obs0, {12'd0, 12'd0, 8'b1001_1000});

      // One full line of the default mode.
      act_fall_h = -1; hs_rise_h = -1; hs_fall_h = -1;
      hs_rise_i = -1; hso_rise_i = -1; wrap_v = -1; ls_cnt = 0;
      p_act = if0.VGA_active; p_hs = if0.VGA_HS; p_hso = if0.VGA_HS_OUT;
      for (int i = 1; i <= 1690; i++) begin
         @(negedge clk);
         if (p_act && !if0.VGA_active && act_fall_h < 0) act_fall_h = int'(if0.VGA_horzCoord);
         if (!p_hs && if0.VGA_HS && hs_rise_h < 0) begin
            hs_rise_h = int'(if0.VGA_horzCoord);
            hs_rise_i = i;
         end
         if (p_hs && !if0.VGA_HS && hs_fall_h < 0) hs_fall_h = int'(if0.VGA_horzCoord);
         if (!p_hso && if0.VGA_HS_OUT && hso_rise_i < 0) hso_rise_i = i;
         if (if0.line_start) begin
            ls_cnt++;
            if (wrap_v < 0) wrap_v = int'(if0.VGA_vertCoord);
         end
         p_act = if0.VGA_active; p_hs = if0.VGA_HS; p_hso = if0.VGA_HS_OUT;
      end
      cmp("active_fall_h", act_fall_h, 1280);
      cmp("hs_rise_h", hs_rise_h, 1328);
      cmp("hs_fall_h", hs_fall_h, 1440);
      cmp("hs_out_delay", hso_rise_i - hs_rise_i, 2);
      cmp("line_start_count", ls_cnt, 1);
      cmp("wrap_v", wrap_v, 1);

      // Directed table on the small instance.
      for (int k = 0; k < 16; k++) begin
         rst   = tbl[k].rst;
         pe[1] = tbl[k].pe;
         repeat (tbl[k].ncyc) @(negedge clk);
         eh = tbl[k].h[11:0];
         ev = tbl[k].v[11:0];
         cmp($sformatf("table%0d", k), {obs1[31:3], 3'b000}, {eh, ev, tbl[k].f, 3'b000});
      end

      // PIX_EN held low: everything frozen.
      rst = 1'b0;
      pe  = 3'b111;
      repeat (7) @(negedge clk);
      pe[2] = 1'b0;
      @(negedge clk);
      snap = obs2;
      repeat (100) @(negedge clk);
      cmp("freeze", obs2, snap);

      // Frame period of the 16x10 instance is 160 advances.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pe  = 3'b111;
      fs_cnt = 0; fs_first = -1; fs_second = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (if2.frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
      end
      cmp("frame_count", fs_cnt, 3);
      cmp("frame_period", fs_second - fs_first, 160);

      // Reset in the middle of a frame on the small instance.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (130) @(negedge clk);
      cmp("mid_pos", {8'd0, obs1[31:8]}, {8'd0, 12'd4, 12'd5});
      rst = 1'b1;
      @(negedge clk);
      cmp("mid_reset", obs1, {12'd24, 12'd13, 8'b0000_0000});
      rst = 1'b0;
      @(negedge clk);
      cmp("mid_reset_restart", {obs1[31:3], 3'b000}, {12'd0, 12'd0, 5'b10011, 3'b000});

      // Randomised PIX_EN and occasional resets against the reference.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         pe  = 3'($urandom);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the oscilloscope display: free-running horizontal/vertical counters produce the `VGA_horzCoord`/`VGA_vertCoord` pair consumed by every label, grid and waveform renderer, plus sync, blanking and frame/line strobes. Syncs are re-timed through a delay line so they stay aligned with the registered pixel colour leaving the render pipeline. Default mode is 1280x1024@60 Hz with a 108 MHz pixel clock.

## Interface
- `H_VISIBLE`, default 1280: active pixels per line.
- `H_FP`, default 48: horizontal front porch.
- `H_SYNC`, default 112: horizontal sync width.
- `H_BP`, default 248: horizontal back porch.
- `V_VISIBLE`, default 1024: active lines.
- `V_FP`, default 1: vertical front porch.
- `V_SYNC`, default 3: vertical sync width.
- `V_BP`, default 38: vertical back porch.
- `SYNC_POL`, default 1: asserted sync level (1 = positive).
- `PIPE_DEPTH`, default 2, range 0..8: sync/active delay in advancing cycles.
- `CLK_VGA`  in  1  pixel clock. One clock only. Reset is synchronous and active-high.
- `RESET`  in  1  synchronous, active-high.
- `PIX_EN`  in  1  advance enable; tie high for a 1:1 pixel clock.
- `VGA_horzCoord`  out  12  current column, 0..H_TOTAL-1.
- `VGA_vertCoord`  out  12  current row, 0..V_TOTAL-1.
- `VGA_active`  out  1  high when the coordinate is in the visible area.
- `VGA_HS`, `VGA_VS`  out  1  undelayed syncs for the current coordinate.
- `line_start`  out  1  one-CLK strobe on entry to h=0.
- `frame_start`  out  1  one-CLK strobe on entry to (0,0).
- `VGA_HS_OUT`, `VGA_VS_OUT`, `VGA_active_OUT`  out  1  delayed by PIPE_DEPTH; these drive the pins.

## Operation
- Derived values: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1688); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (1066).
- **Advancing edge:** a CLK_VGA edge with RESET=0 and PIX_EN=1.
  - h increments.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 together with the h wrap, v wraps to 0.
- **Decoded outputs:** registered together with the counters, so they always describe the coordinate presented in the same cycle.
  - VGA_active = (h < H_VISIBLE) && (v < V_VISIBLE).
  - VGA_HS = SYNC_POL when h is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [1328,1440); otherwise ~SYNC_POL.
  - VGA_VS = SYNC_POL when v is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. [1025,1028); otherwise ~SYNC_POL. VS changes only together with v.
- **PIX_EN=0:** counters, decoded levels and the delay line hold their values.
- **Strobes:** line_start and frame_start are high for exactly one CLK cycle after the advancing edge that enters h=0 or (0,0), respectively. They clear on the next edge regardless of PIX_EN.
- **Delay line:** VGA_*_OUT is the PIPE_DEPTH-stage shift of {HS, VS, active}, shifting only on advancing edges. With PIPE_DEPTH=0, VGA_*_OUT equals the undelayed signal.
- **Reset:** every reset edge loads the following. This position lies in the back porch, so the decoded values are consistent.
  - h = H_TOTAL-1 (1687), v = V_TOTAL-1 (1065).
  - VGA_active = 0.
  - VGA_HS and VGA_VS = ~SYNC_POL.
  - Strobes = 0.
  - All delay-line stages = {~SYNC_POL, ~SYNC_POL, 0}.
- **First advance after reset:** (0,0), active=1, line_start=1, frame_start=1.
- **Reset mid-frame:** takes effect on that edge and overrides PIX_EN. No partial line or frame is completed.

## Timing
- Coordinate-to-decoded-output latency: 0 cycles, since both are registered together.
- Undelayed to `_OUT` latency: PIPE_DEPTH advancing cycles.
- Line period: 1688 advances. Frame period: 1688*1066 = 1,799,408 advances.
- HS high for 112 advances per line. VS high for 3*1688 advances per frame.
- Coordinates never exceed H_TOTAL-1 / V_TOTAL-1. The counter widths (12 bits) require H_TOTAL ≤ 4096 and V_TOTAL ≤ 4096; check this by elaboration-time assertion.

## Structure
- **Package `vga_timing_pkg`:**
  - the 1280x1024@60 constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - the HS/VS start/end derivations;
  - the coordinate width constant (12).
- **Sub-module `sync_delay_line`:** parameterised width and depth, with enable and synchronous reset to a parameterised init vector. Instantiated once, for 3 bits.

## Test plan
- **Reset release, PIX_EN=1:** before release, coordinates = (1687,1065), active=0, syncs=0. First edge after release gives (0,0), active=1, frame_start=1 for one cycle.
- **One full line:** active falls when h goes 1279→1280. HS rises at h=1328 and falls at h=1440. line_start pulses at each wrap to h=0, and v increments at that wrap.
- **Full frame:** VS is high for v=1025..1027 only. frame_start pulses once every 1,799,408 cycles. Coordinates never exceed (1687,1065).
- **PIX_EN toggled 1/0 alternately:** coordinates advance every second cycle and strobes stay one CLK wide. With PIX_EN held low for 100 cycles, all outputs are frozen.
- **PIPE_DEPTH=2:** VGA_HS_OUT rises exactly 2 advances after VGA_HS. With PIPE_DEPTH=0, the _OUT signals are identical to the undelayed ones.
- **RESET pulsed at (700,500) mid-frame:** the next cycle reads (1687,1065) with all _OUT signals inactive. The following advance is (0,0) with frame_start=1.
